mem_wb_stage: RTL
=================

# mem_wb_stage

Memory-access stage of the in-order RV32I pipeline. Sits between the execute stage and the register file write port. Non-memory results pass to the write port one cycle after acceptance. Loads and stores run as byte-serial transactions on the 8-bit unified memory port; the stage stalls the upstream pipeline until each transaction completes.

## Interface
- No parameters. Widths use the global `RegLen` (32) and `RegAddrLen` (5) macros.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid_i  in  1  execute stage presents an instruction this cycle
- ex_rd_enable_i  in  1  instruction writes rd
- ex_rd_addr_i  in  5  destination register
- ex_result_i  in  32  ALU result; byte address for memory ops
- ex_mem_op_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; any other value is NONE
- ex_store_data_i  in  32  store data (rs2)
- stall_o  out  1  upstream must hold its state and inputs this cycle
- mem_a_o  out  32  memory byte address
- mem_wr_o  out  1  1 = write mem_dout_o to mem_a_o this cycle
- mem_dout_o  out  8  write byte
- mem_din_i  in  8  read byte; valid the cycle after its address is presented
- rd_enable_o  out  1  register file write enable
- rd_addr_o  out  5  register file write address
- rd_data_o  out  32  register file write data
- misalign_o  out  1  misaligned access pulse (only with `MEM_MISALIGN_CHECK_EN`)

## Operation
- States: IDLE, LOAD, STORE, WB. Byte counter cnt[2:0]. Size n = 1 (B/BU/SB), 2 (H/HU/SH), 4 (W/SW).
- IDLE, ex_valid_i=1, op NONE: latch rd fields and ex_result_i into the rd outputs. No stall. Stay in IDLE.
- IDLE, ex_valid_i=1, load or store: stall_o=1 combinationally in the accept cycle. Latch op, address, store data, and rd fields. Go to LOAD or STORE with cnt=0.
- LOAD: present address addr+cnt. Capture mem_din_i one cycle later into byte cnt-1, little-endian. After the last byte is captured, go to WB.
- Result extension: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- WB: drive rd_enable_o (the latched ex_rd_enable_i), rd_addr_o, and the assembled rd_data_o for one cycle. stall_o=0. Return to IDLE. A new instruction can be accepted in this same cycle.
- STORE: mem_wr_o=1, mem_a_o=addr+cnt, mem_dout_o=store byte cnt, for cnt=0..n-1. After the last byte, return to IDLE. rd_enable_o stays 0 for stores.
- While not in IDLE, ex_* inputs are ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32: 0xFFFFFFFF+1 = 0.
- rd_enable_o is 1 for exactly one cycle per writing instruction and 0 otherwise. x0 filtering is left to the register file.
- With rd_enable_o=0, rd_addr_o and rd_data_o hold their last values.
- Reset values: state IDLE, cnt 0, stall_o 0, mem_wr_o 0, mem_a_o 0, mem_dout_o 0, rd_enable_o 0, rd_addr_o 0, rd_data_o 0, misalign_o 0.
- Reset mid-transaction aborts it: mem_wr_o=0 in the cycle after rst is sampled, and no writeback occurs.

## Timing
- Accept cycle T. All outputs except stall_o are registered.
- Non-memory op: rd outputs valid at T+1.
- Load, size n: addresses at T+1..T+n; bytes sampled at T+2..T+n+1; WB at T+n+2; stall_o high T..T+n+1.
- LW latency is 6 cycles. LB latency is 3 cycles.
- Store, size n: writes at T+1..T+n; stall_o high T..T+n; next accept at T+n+1.
- mem_wr_o=0 in every cycle that is not a STORE-state cycle.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: an H/HU/SH access with addr[0]=1, or a W/SW access with addr[1:0]≠0, is not performed.
  - misalign_o=1 at T+1 for one cycle. No memory access, no writeback. stall_o high only in T. State returns to IDLE at T+1.
- Not defined: misalign_o is tied 0, and every alignment is performed byte-serially as above.

## Test plan
- ADD result: ex_result_i=0x12345678, rd=5, op NONE at T -> rd_enable_o=1, rd_addr_o=5, rd_data_o=0x12345678 at T+1; stall_o never high.
- LW: addr 0x100, memory bytes 78 56 34 12, rd=3 -> addresses 0x100..0x103 at T+1..T+4; rd_data_o=0x12345678 at T+6; stall_o high T..T+5.
- LB/LBU: byte 0x80, rd=7 -> LB writes 0xFFFFFF80 and LBU writes 0x00000080, each at T+3.
- SH: addr 0x20, data 0xAABBCCDD -> mem_wr_o=1 with (0x20,0xDD) at T+1 and (0x21,0xCC) at T+2; rd_enable_o stays 0; new op accepted at T+3.
- Wrap and reset:
  - LW at 0xFFFFFFFE (check disabled) -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
  - SW with rst asserted at T+2 -> mem_wr_o=0 from T+3, all outputs at reset values.
- Misalign (`MEM_MISALIGN_CHECK_EN`): LW at 0x102 -> misalign_o=1 at T+1; mem_wr_o=0 and rd_enable_o=0 throughout; stall_o high only at T.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: ALU results pass straight to the rd port; loads and stores run byte-serially on an 8-bit port.
// Optional `MEM_MISALIGN_CHECK_EN rejects misaligned H/W accesses with a one-cycle misalign_o pulse.

`ifndef RegLen
`define RegLen 32
`endif
`ifndef RegAddrLen
`define RegAddrLen 5
`endif

module mem_wb_stage (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid_i,
    input  logic                   ex_rd_enable_i,
    input  logic [`RegAddrLen-1:0] ex_rd_addr_i,
    input  logic [`RegLen-1:0]     ex_result_i,
    input  logic [3:0]             ex_mem_op_i,
    input  logic [`RegLen-1:0]     ex_store_data_i,
    output logic                   stall_o,
    output logic [`RegLen-1:0]     mem_a_o,
    output logic                   mem_wr_o,
    output logic [7:0]             mem_dout_o,
    input  logic [7:0]             mem_din_i,
    output logic                   rd_enable_o,
    output logic [`RegAddrLen-1:0] rd_addr_o,
    output logic [`RegLen-1:0]     rd_data_o,
    output logic                   misalign_o
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, WB} state_t;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_t;

    function automatic logic [2:0] op_size(input mem_op_t op);
        case (op)
            OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
            OP_LW, OP_SW:         op_size = 3'd4;
            default:              op_size = 3'd1;
        endcase
    endfunction

    function automatic logic [`RegLen-1:0] extend(input mem_op_t op, input logic [`RegLen-1:0] b);
        case (op)
            OP_LB:   extend = {{24{b[7]}}, b[7:0]};
            OP_LH:   extend = {{16{b[15]}}, b[15:0]};
            OP_LBU:  extend = {24'd0, b[7:0]};
            OP_LHU:  extend = {16'd0, b[15:0]};
            default: extend = b;
        endcase
    endfunction

    state_t                   state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    mem_op_t                  op_q, op_d;
    logic [`RegLen-1:0]       addr_q, addr_d;
    logic [`RegLen-1:0]       sdata_q, sdata_d;
    logic                     rd_en_q, rd_en_d;
    logic [`RegAddrLen-1:0]   rd_dst_q, rd_dst_d;
    logic [`RegLen-1:0]       ld_buf_q, ld_buf_d;

    logic [`RegLen-1:0]       mem_a_d;
    logic                     mem_wr_d;
    logic [7:0]               mem_dout_d;
    logic                     rd_enable_d;
    logic [`RegAddrLen-1:0]   rd_addr_d;
    logic [`RegLen-1:0]       rd_data_d;

    mem_op_t                  ex_op;
    logic                     ex_is_mem;
    logic                     ex_is_store;
    logic                     accept;
    logic                     misaligned;
    logic [1:0]               byte_idx;

    always_comb begin
        ex_op       = (ex_mem_op_i > 4'd8) ? OP_NONE : mem_op_t'(ex_mem_op_i);
        ex_is_mem   = (ex_op != OP_NONE);
        ex_is_store = (ex_op == OP_SB) || (ex_op == OP_SH) || (ex_op == OP_SW);
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (ex_op)
            OP_LH, OP_LHU, OP_SH: misaligned = ex_result_i[0];
            OP_LW, OP_SW:         misaligned = |ex_result_i[1:0];
            default:              misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        rd_en_d     = rd_en_q;
        rd_dst_d    = rd_dst_q;
        ld_buf_d    = ld_buf_q;
        mem_a_d     = mem_a_o;
        mem_wr_d    = 1'b0;
        mem_dout_d  = mem_dout_o;
        rd_enable_d = 1'b0;
        rd_addr_d   = rd_addr_o;
        rd_data_d   = rd_data_o;
        stall_o     = 1'b0;
        accept      = 1'b0;
        byte_idx    = cnt_q[1:0] - 2'd1;

        case (state_q)
            IDLE: accept = ex_valid_i;
            WB: begin
                state_d = IDLE;
                accept  = ex_valid_i;
            end
            LOAD: begin
                stall_o = 1'b1;
                // Byte requested at cnt-1 arrives now; cnt==size means the final byte is on mem_din_i.
                if (cnt_q != 3'd0)
                    ld_buf_d[{byte_idx, 3'b000} +: 8] = mem_din_i;
                if (cnt_q == op_size(op_q)) begin
                    state_d     = WB;
                    cnt_d       = 3'd0;
                    rd_enable_d = rd_en_q;
                    if (rd_en_q) begin
                        rd_addr_d = rd_dst_q;
                        rd_data_d = extend(op_q, ld_buf_d);
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d < op_size(op_q))
                        mem_a_d = addr_q + {29'd0, cnt_d};
                end
            end
            STORE: begin
                stall_o = 1'b1;
                if (cnt_q + 3'd1 < op_size(op_q)) begin
                    cnt_d      = cnt_q + 3'd1;
                    mem_wr_d   = 1'b1;
                    mem_a_d    = addr_q + {29'd0, cnt_d};
                    mem_dout_d = sdata_q[{cnt_d[1:0], 3'b000} +: 8];
                end else begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (!ex_is_mem) begin
                state_d     = IDLE;
                rd_enable_d = ex_rd_enable_i;
                if (ex_rd_enable_i) begin
                    rd_addr_d = ex_rd_addr_i;
                    rd_data_d = ex_result_i;
                end
            end else begin
                stall_o = 1'b1;
                if (misaligned) begin
                    state_d = IDLE;
                end else begin
                    state_d  = ex_is_store ? STORE : LOAD;
                    cnt_d    = 3'd0;
                    op_d     = ex_op;
                    addr_d   = ex_result_i;
                    sdata_d  = ex_store_data_i;
                    rd_en_d  = ex_rd_enable_i && !ex_is_store;
                    rd_dst_d = ex_rd_addr_i;
                    ld_buf_d = '0;
                    mem_a_d  = ex_result_i;
                    if (ex_is_store) begin
                        mem_wr_d   = 1'b1;
                        mem_dout_d = ex_store_data_i[7:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= OP_NONE;
            addr_q      <= '0;
            sdata_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_dst_q    <= '0;
            ld_buf_q    <= '0;
            mem_a_o     <= '0;
            mem_wr_o    <= 1'b0;
            mem_dout_o  <= '0;
            rd_enable_o <= 1'b0;
            rd_addr_o   <= '0;
            rd_data_o   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            rd_en_q     <= rd_en_d;
            rd_dst_q    <= rd_dst_d;
            ld_buf_q    <= ld_buf_d;
            mem_a_o     <= mem_a_d;
            mem_wr_o    <= mem_wr_d;
            mem_dout_o  <= mem_dout_d;
            rd_enable_o <= rd_enable_d;
            rd_addr_o   <= rd_addr_d;
            rd_data_o   <= rd_data_d;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            misalign_o <= 1'b0;
        else
            misalign_o <= accept && ex_is_mem && misaligned;
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule
